output_register_controller: RTL and testbench

Output port stage that sits directly upstream of the VGA output interface. Accepts bytes from the basic computer's OUT instruction into a small FIFO and drives the output register value shown on screen. Holds each byte stable for a fixed number of whole VGA frames, aligned to frame boundaries, then advances to the next byte. Generates the FGO flag and output interrupt request back to the CPU.

---
 rtl/basic_computer_pkg.sv | 13 +
 rtl/output_register_controller_byte_fifo.sv | 67 ++++++
 rtl/output_register_controller.sv | 125 ++++++++++++
 tb/tb_output_register_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/basic_computer_pkg.sv
// Shared definitions for the basic computer output path: controller state
// encoding and the output data width.
package basic_computer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHOW  = 2'd2
  } out_state_e;

  localparam int OUT_WIDTH = 8;

endpackage

// File: rtl/output_register_controller_byte_fifo.sv
// Small circular byte FIFO. A push into a full FIFO and a pop from an empty
// FIFO are ignored; pointers wrap modulo DEPTH.
module byte_fifo
  import basic_computer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [OUT_WIDTH-1:0]   wr_data,
  output logic [OUT_WIDTH-1:0]   rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [OUT_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  // Full is judged on the pre-edge count, so a push that coincides with a
  // pop on a full FIFO is still dropped.
  assign full      = (count_r == FULL_COUNT);
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/output_register_controller.sv
// Output port stage: queues OUT bytes and shows each one for a whole number of
// VGA frames, starting on a frame boundary, with FGO/interrupt back to the CPU.
module output_register_controller
  import basic_computer_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int FRAMES_PER_BYTE = 2
) (
  input  logic                   mhz25_clock,
  input  logic                   reset,
  input  logic                   cpu_out_write,
  input  logic [OUT_WIDTH-1:0]   cpu_out_data,
  input  logic                   ien,
  input  logic                   frame_start,
  output logic [OUT_WIDTH-1:0]   outr_outdata,
  output logic                   fgo,
  output logic                   output_interrupt,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   byte_done,
  output logic                   overflow
);

  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_BYTE - 1);

  out_state_e           state_r, state_n;
  logic [7:0]           frame_cnt_r, frame_cnt_n;
  logic [OUT_WIDTH-1:0] outr_r, outr_n;
  logic                 byte_done_r, byte_done_n;
  logic                 overflow_r, overflow_n;
  logic                 pop_s;
  logic [OUT_WIDTH-1:0] head_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (mhz25_clock),
    .reset   (reset),
    .push    (cpu_out_write),
    .pop     (pop_s),
    .wr_data (cpu_out_data),
    .rd_data (head_s),
    .count   (fifo_count),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Next-state, frame counting and byte hand-off.
  always_comb begin
    state_n     = state_r;
    frame_cnt_n = frame_cnt_r;
    outr_n      = outr_r;
    byte_done_n = 1'b0;
    pop_s       = 1'b0;
    overflow_n  = overflow_r | (cpu_out_write & fifo_full_s);
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          outr_n  = head_s;
          pop_s   = 1'b1;
          state_n = ALIGN;
        end else begin
          state_n = IDLE;
        end
      end
      ALIGN: begin
        // Wait out the partial frame the byte was loaded in.
        if (frame_start) begin
          frame_cnt_n = 8'd0;
          state_n     = SHOW;
        end else begin
          state_n = ALIGN;
        end
      end
      SHOW: begin
        if (frame_start) begin
          if (frame_cnt_r == LAST_FRAME) begin
            byte_done_n = 1'b1;
            frame_cnt_n = 8'd0;
            if (!fifo_empty_s) begin
              outr_n  = head_s;
              pop_s   = 1'b1;
              state_n = SHOW;
            end else begin
              state_n = IDLE;
            end
          end else begin
            frame_cnt_n = frame_cnt_r + 8'd1;
          end
        end else begin
          state_n = SHOW;
        end
      end
      default: begin
        state_n     = IDLE;
        frame_cnt_n = 8'd0;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge mhz25_clock) begin
    if (reset) begin
      state_r     <= IDLE;
      frame_cnt_r <= 8'd0;
      outr_r      <= {OUT_WIDTH{1'b0}};
      byte_done_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      frame_cnt_r <= frame_cnt_n;
      outr_r      <= outr_n;
      byte_done_r <= byte_done_n;
      overflow_r  <= overflow_n;
    end
  end

  assign outr_outdata     = outr_r;
  assign byte_done        = byte_done_r;
  assign overflow         = overflow_r;
  assign fgo              = ~fifo_full_s;
  assign output_interrupt = ien & fgo;

endmodule

// File: tb/tb_output_register_controller.sv
// Directed bench for output_register_controller (DEPTH=4, FRAMES_PER_BYTE=2)
// with hand-computed expectations checked by immediate assertions.
module tb_output_register_controller;
  import basic_computer_pkg::*;

  logic       mhz25_clock;
  logic       reset;
  logic       cpu_out_write;
  logic [7:0] cpu_out_data;
  logic       ien;
  logic       frame_start;
  logic [7:0] outr_outdata;
  logic       fgo;
  logic       output_interrupt;
  logic [2:0] fifo_count;
  logic       byte_done;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  output_register_controller #(
    .DEPTH(4),
    .FRAMES_PER_BYTE(2)
  ) dut (
    .mhz25_clock      (mhz25_clock),
    .reset            (reset),
    .cpu_out_write    (cpu_out_write),
    .cpu_out_data     (cpu_out_data),
    .ien              (ien),
    .frame_start      (frame_start),
    .outr_outdata     (outr_outdata),
    .fgo              (fgo),
    .output_interrupt (output_interrupt),
    .fifo_count       (fifo_count),
    .byte_done        (byte_done),
    .overflow         (overflow)
  );

  initial mhz25_clock = 1'b0;
  always #20 mhz25_clock = ~mhz25_clock;

  task automatic tick();
    @(posedge mhz25_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    cpu_out_write = 1'b1;
    cpu_out_data  = d;
    tick();
    cpu_out_write = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_out_write = 1'b0; cpu_out_data = 8'h00;
    ien = 1'b0; frame_start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_outr", 32'(outr_outdata), 32'h00);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_fgo", 32'(fgo), 32'd1);
    check("rst_done", 32'(byte_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_irq", 32'(output_interrupt), 32'd0);
    check("rst_state", 32'(dut.state_r), 32'(IDLE));

    // single byte loaded mid-frame
    tick(); tick();
    write_byte(8'hA5);
    check("t1_count1", 32'(fifo_count), 32'd1);
    check("t1_outr_old", 32'(outr_outdata), 32'h00);
    tick();
    check("t1_outr", 32'(outr_outdata), 32'hA5);
    check("t1_count0", 32'(fifo_count), 32'd0);
    check("t1_align", 32'(dut.state_r), 32'(ALIGN));
    frame();
    check("t1_show", 32'(dut.state_r), 32'(SHOW));
    check("t1_done_a", 32'(byte_done), 32'd0);
    frame();
    check("t1_done_b", 32'(byte_done), 32'd0);
    frame();
    check("t1_done_c", 32'(byte_done), 32'd1);
    check("t1_idle", 32'(dut.state_r), 32'(IDLE));
    tick();
    check("t1_done_pulse", 32'(byte_done), 32'd0);
    check("t1_hold", 32'(outr_outdata), 32'hA5);

    // three back-to-back writes
    ien = 1'b1;
    write_byte(8'h11);
    check("t2_c1", 32'(fifo_count), 32'd1);
    write_byte(8'h22);
    check("t2_outr11", 32'(outr_outdata), 32'h11);
    check("t2_c2", 32'(fifo_count), 32'd1);
    write_byte(8'h33);
    check("t2_peak", 32'(fifo_count), 32'd2);
    check("t2_irq", 32'(output_interrupt), 32'd1);
    frame(); frame();
    check("t2_gap", 32'(byte_done), 32'd0);
    frame();
    check("t2_done1", 32'(byte_done), 32'd1);
    check("t2_outr22", 32'(outr_outdata), 32'h22);
    check("t2_c3", 32'(fifo_count), 32'd1);
    frame();
    check("t2_gap2", 32'(byte_done), 32'd0);
    frame();
    check("t2_done2", 32'(byte_done), 32'd1);
    check("t2_outr33", 32'(outr_outdata), 32'h33);
    check("t2_c4", 32'(fifo_count), 32'd0);
    frame(); frame();
    check("t2_done3", 32'(byte_done), 32'd1);
    check("t2_idle", 32'(dut.state_r), 32'(IDLE));
    check("t2_hold", 32'(outr_outdata), 32'h33);

    // fill the FIFO while a byte is on screen, then overflow it
    write_byte(8'h44);
    tick();
    check("t3_outr44", 32'(outr_outdata), 32'h44);
    write_byte(8'h55);
    write_byte(8'h66);
    write_byte(8'h77);
    check("t3_fgo_not_full", 32'(fgo), 32'd1);
    write_byte(8'h88);
    check("t3_full", 32'(fifo_count), 32'd4);
    check("t3_fgo0", 32'(fgo), 32'd0);
    check("t3_irq0", 32'(output_interrupt), 32'd0);
    check("t3_no_ovf", 32'(overflow), 32'd0);
    write_byte(8'h99);
    check("t3_drop_count", 32'(fifo_count), 32'd4);
    check("t3_ovf", 32'(overflow), 32'd1);
    frame(); frame(); frame();
    check("t3_outr55", 32'(outr_outdata), 32'h55);
    check("t6_c3", 32'(fifo_count), 32'd3);
    check("t6_irq1", 32'(output_interrupt), 32'd1);
    frame(); frame();
    check("t3_outr66", 32'(outr_outdata), 32'h66);
    check("t4_c2", 32'(fifo_count), 32'd2);

    // write coinciding with a byte_done pop
    frame();
    cpu_out_write = 1'b1; cpu_out_data = 8'hAA; frame_start = 1'b1;
    tick();
    cpu_out_write = 1'b0; frame_start = 1'b0;
    check("t4_done", 32'(byte_done), 32'd1);
    check("t4_outr77", 32'(outr_outdata), 32'h77);
    check("t4_keep2", 32'(fifo_count), 32'd2);
    frame(); frame();
    check("t4_outr88", 32'(outr_outdata), 32'h88);
    frame(); frame();
    check("t4_outrAA", 32'(outr_outdata), 32'hAA);
    check("t4_empty", 32'(fifo_count), 32'd0);
    frame(); frame();
    check("t4_idle", 32'(dut.state_r), 32'(IDLE));
    check("t4_final", 32'(outr_outdata), 32'hAA);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);

    // reset during SHOW with three bytes queued
    write_byte(8'h01);
    tick();
    frame();
    write_byte(8'h02);
    write_byte(8'h03);
    write_byte(8'h04);
    check("t5_c3", 32'(fifo_count), 32'd3);
    check("t5_show", 32'(dut.state_r), 32'(SHOW));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_outr", 32'(outr_outdata), 32'h00);
    check("t5_count", 32'(fifo_count), 32'd0);
    check("t5_fgo", 32'(fgo), 32'd1);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_state", 32'(dut.state_r), 32'(IDLE));
    check("t5_fcnt", 32'(dut.frame_cnt_r), 32'd0);
    tick();
    check("t5_stay_idle", 32'(dut.state_r), 32'(IDLE));
    check("t5_outr_hold", 32'(outr_outdata), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
